// File: rtl/cp0_unit.sv
// cp0_unit: coprocessor-0 for the pipelined MIPS core.
// Holds SR, Cause and EPC. Decides each cycle whether to take an
// interrupt or an exception, serves mfc0/mtc0, and clears EXL on eret.
// Build option: define CP0_PRID_EN to make address 15 return the PRId constant.
module cp0_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  CP0Addr,
  input  logic [31:0] CP0In,
  output logic [31:0] CP0Out,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic [31:0] EPCOut,
  output logic        Req
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  // The EXL bit is the NORMAL/HANDLER state of the block.
  typedef enum logic {
    NORMAL  = 1'b0,
    HANDLER = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  im;
  logic        ie;
  logic        bd;
  logic [5:0]  ip;
  logic [4:0]  exc_code;
  logic [31:0] epc;

  logic        exl;
  logic        int_req;
  logic        exc_req;
  logic        sr_wr;
  logic        epc_wr;
  logic [31:0] epc_src;
  logic [31:0] sr_val;
  logic [31:0] cause_val;

  assign exl     = (state_q == HANDLER);
  assign int_req = (|(HWInt & im)) & ie & ~exl;
  assign exc_req = (ExcCodeIn != 5'd0) & ~exl;
  assign Req     = (int_req | exc_req) & ~reset;

  // A taken exception/interrupt wins over a same-cycle mtc0.
  assign sr_wr   = en & ~Req & (CP0Addr == ADDR_SR);
  assign epc_wr  = en & ~Req & (CP0Addr == ADDR_EPC);

  // Restart point: the branch itself when the faulting instruction is in a delay slot.
  assign epc_src = BDIn ? (VPC - 32'd4) : VPC;

  assign sr_val    = {16'b0, im, 8'b0, exl, ie};
  assign cause_val = {bd, 15'b0, ip, 3'b0, exc_code, 2'b0};
  assign EPCOut    = epc;

  // Next EXL state: enter HANDLER on Req; mtc0 SR then eret decide otherwise.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    if (Req) begin
      state_d = HANDLER;
    end else begin
      if (sr_wr) state_d = CP0In[1] ? HANDLER : NORMAL;
      if (EXLClr) state_d = NORMAL;
    end
  end

  // State register plus the SR/Cause/EPC fields.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q  <= NORMAL;
      im       <= '0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ip       <= '0;
      exc_code <= '0;
      epc      <= '0;
    end else begin
      state_q <= state_d;
      ip      <= HWInt;
      if (Req) begin
        exc_code <= int_req ? 5'd0 : ExcCodeIn;
        bd       <= BDIn;
        epc      <= epc_src & 32'hFFFF_FFFC;
      end else begin
        if (sr_wr) begin
          im <= CP0In[15:10];
          ie <= CP0In[0];
        end
        if (epc_wr) epc <= CP0In & 32'hFFFF_FFFC;
      end
    end
  end

  // mfc0 read mux; unimplemented addresses read 0.
  always_comb begin
    CP0Out = 32'h0;
    case (CP0Addr)
      ADDR_SR:    CP0Out = sr_val;
      ADDR_CAUSE: CP0Out = cause_val;
      ADDR_EPC:   CP0Out = epc;
`ifdef CP0_PRID_EN
      ADDR_PRID:  CP0Out = 32'h4255_4141;
`else
      ADDR_PRID:  CP0Out = 32'h0;
`endif
      default:    CP0Out = 32'h0;
    endcase
  end

endmodule
